// File: rtl/apb4_ram_pkg.sv
// Shared types and helpers for the APB4 RAM slave: controller states,
// response codes and the byte-lane shift derived from the bus width.
package apb4_ram_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCESS
  } state_t;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  // log2 of the byte count per word; valid for 8/16/32/64-bit buses
  function automatic int unsigned lsb_of(input int unsigned data_width);
    int unsigned l;
    l = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if ((data_width / 8) > (32'd1 << i)) l = i + 1;
    end
    return l;
  endfunction

endpackage

// File: rtl/apb4_ram_array.sv
// DEPTH x DATA_WIDTH word storage with one asynchronous read port, one
// byte-enable write port and a single-word clear port used by the reset sweep.
module apb4_ram_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    clr_en,
  input  logic [AW-1:0]           clr_addr,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [AW-1:0]           raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Non-power-of-two depths leave unbacked indices; those read as zero
  assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/apb4_ram.sv
// APB4 slave RAM: word-addressed storage with byte strobes, programmable
// wait states, address/alignment error response and a post-reset clear sweep.
module apb4_ram
  import apb4_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned WAIT_STATES    = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned LSB = lsb_of(DATA_WIDTH);
  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned AW  = $clog2(DEPTH);

  state_t                state;
  logic [AW-1:0]         clr_cnt;
  logic [AW-1:0]         idx_q;
  logic [3:0]            wait_cnt;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] prdata_q;

  logic [ADDR_WIDTH-1:0] idx_full;
  logic                  err_in;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  we;
  logic                  clr_en;

  assign idx_full = PADDR >> LSB;
  assign err_in   = ((PADDR & ADDR_WIDTH'(NB - 1)) != '0) ||
                    (idx_full >= ADDR_WIDTH'(DEPTH));
  assign rd_addr  = idx_full[AW-1:0];

  assign PREADY  = (state == ST_ACCESS) && (wait_cnt == '0);
  assign PSLVERR = PREADY && (err_q == RESP_ERR);
  assign PRDATA  = prdata_q;

  assign clr_en = (state == ST_INIT);
  assign we     = PREADY && PSEL && PENABLE && PWRITE && (err_q == RESP_OKAY);

  apb4_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_array (
    .clk      (PCLK),
    .clr_en   (clr_en),
    .clr_addr (clr_cnt),
    .we       (we),
    .waddr    (idx_q),
    .wstrb    (PSTRB),
    .wdata    (PWDATA),
    .raddr    (rd_addr),
    .rdata    (rdata)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
      clr_cnt  <= '0;
      idx_q    <= '0;
      wait_cnt <= '0;
      err_q    <= RESP_OKAY;
      prdata_q <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (clr_cnt == AW'(DEPTH - 1)) state <= ST_IDLE;
          else                           clr_cnt <= clr_cnt + 1'b1;
        end
        // PENABLE is not required here so a transfer held off by the
        // clear sweep is still accepted once the sweep finishes
        ST_IDLE: begin
          if (PSEL) begin
            err_q    <= err_in ? RESP_ERR : RESP_OKAY;
            idx_q    <= rd_addr;
            wait_cnt <= 4'(WAIT_STATES);
            if (!PWRITE) prdata_q <= err_in ? '0 : rdata;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
          if (!PSEL)                              state <= ST_IDLE;
          else if (PENABLE && (wait_cnt == '0))   state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_ram.sv
// Scoreboard bench for apb4_ram: the driver pushes responses predicted by a
// word-array model; a negedge monitor pops and compares on each completion.
module tb_apb4_ram;

  localparam int unsigned DW    = 32;
  localparam int unsigned AWD   = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned WS    = 3;

  logic            PCLK = 1'b0;
  logic            PRESETn = 1'b0;
  logic            PSEL = 1'b0;
  logic            PENABLE = 1'b0;
  logic            PWRITE = 1'b0;
  logic [AWD-1:0]  PADDR = '0;
  logic [DW-1:0]   PWDATA = '0;
  logic [DW/8-1:0] PSTRB = '0;
  logic [DW-1:0]   PRDATA;
  logic            PREADY;
  logic            PSLVERR;

  apb4_ram #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AWD),
    .DEPTH          (DEPTH),
    .WAIT_STATES    (WS),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          waits;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] mmem [DEPTH];
  logic [31:0] last_rd;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          wcnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) mmem[i] = '0;
    last_rd = '0;
  endtask

  // Reference behaviour: byte address -> word index, bounds/alignment check,
  // strobed byte merge on writes, reads return the word or zero on error.
  task automatic predict(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int waits);
    exp_t        e;
    bit          err;
    int unsigned idx;
    idx = addr / 4;
    err = (addr % 4 != 0) || (idx >= DEPTH);
    if (wr) begin
      if (!err)
        for (int b = 0; b < 4; b++)
          if (strb[b]) mmem[idx][8*b +: 8] = data[8*b +: 8];
      e.rd = last_rd;
    end else begin
      e.rd    = err ? 32'd0 : mmem[idx];
      last_rd = e.rd;
    end
    e.err   = err;
    e.waits = waits;
    q.push_back(e);
  endtask

  // Starts a SETUP phase at the current time and returns #1 after completion
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int waits);
    int n;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
    PADDR = addr; PWDATA = data; PSTRB = strb;
    predict(wr, addr, data, strb, waits);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!PREADY && n < 100);
    if (!PREADY) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: PREADY=%b after %0d cycles, required 1", PREADY, n);
      q.delete();
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  always @(negedge PCLK) begin
    if (!PRESETn || !PSEL) begin
      wcnt = 0;
    end else if (PENABLE) begin
      if (!PREADY) begin
        wcnt++;
      end else begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_ready: PREADY=1 with no transfer outstanding");
        end else begin
          mon_e = q.pop_front();
          chk("prdata", PRDATA, mon_e.rd);
          chk("pslverr", {31'd0, PSLVERR}, {31'd0, mon_e.err});
          chk("wait_states", wcnt, mon_e.waits);
        end
        wcnt = 0;
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_pready", {31'd0, PREADY}, 32'd0);
    chk("reset_prdata", PRDATA, 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Read issued immediately after reset waits out the whole clear sweep
    xfer(0, 32'h14, 32'h0, 4'h0, int'(DEPTH + WS));

    xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, WS);
    xfer(0, 32'h10, 32'h0, 4'h0, WS);
    xfer(1, 32'h04, 32'h12345678, 4'hF, WS);
    xfer(0, 32'h04, 32'h0, 4'h0, WS);
    xfer(1, 32'h0C, 32'hFFFFFFFF, 4'hF, WS);
    xfer(1, 32'h0C, 32'h00000000, 4'h5, WS);
    xfer(0, 32'h0C, 32'h0, 4'h0, WS);
    chk("strobe_merge_model", last_rd, 32'hFF00FF00);
    xfer(0, 32'h80, 32'h0, 4'h0, WS);
    xfer(1, 32'h00, 32'hA5A5A5A5, 4'hF, WS);
    xfer(1, 32'h02, 32'hFFFFFFFF, 4'hF, WS);
    xfer(0, 32'h00, 32'h0, 4'h0, WS);
    xfer(1, 32'h08, 32'h55AA55AA, 4'h0, WS);
    xfer(0, 32'h08, 32'h0, 4'h0, WS);
    xfer(0, 32'h7D, 32'h0, 4'h0, WS);

    // Aborted write: PSEL dropped during ACCESS, target word must survive
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 32'h10; PWDATA = 32'hAAAAAAAA; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    xfer(0, 32'h10, 32'h0, 4'h0, WS);

    for (int i = 0; i < 80; i++) begin
      xfer(bit'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH * 4 + 7)),
           $urandom, 4'($urandom_range(0, 15)), WS);
      repeat ($urandom_range(0, 2)) begin
        @(posedge PCLK); #1;
      end
    end

    // Reset in the middle of a write's ACCESS phase
    xfer(1, 32'h18, 32'hCAFEF00D, 4'hF, WS);
    xfer(0, 32'h18, 32'h0, 4'h0, WS);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 32'h18; PWDATA = 32'h11111111; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    chk("midreset_prdata", PRDATA, 32'd0);
    chk("midreset_pready", {31'd0, PREADY}, 32'd0);
    chk("midreset_pslverr", {31'd0, PSLVERR}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    q.delete();
    model_reset();
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (DEPTH + 1) @(posedge PCLK);
    #1;
    xfer(0, 32'h18, 32'h0, 4'h0, WS);
    xfer(0, 32'h10, 32'h0, 4'h0, WS);

    repeat (2) @(posedge PCLK);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb4_ram.md
# apb4_ram

Parametrised APB4 slave memory: a word-addressed RAM with byte strobes, configurable wait states, address/alignment error response and a zero-clear sweep after reset. Sits behind the APB interconnect as a generic scratch/config memory, and is the drop-in successor to the fixed 32×32 APB RAM slave.

## Interface
- DATA_WIDTH, 32: bus/word width; multiple of 8, one of 8/16/32/64.
- ADDR_WIDTH, 32: PADDR width.
- DEPTH, 32: number of words; ≥2, need not be a power of two.
- WAIT_STATES, 0: ACCESS cycles with PREADY=0 before completion; 0..15.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = contents retained.

- PCLK  in  1  clock, all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte write enables (ignored on reads).
- PRDATA  out  DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response, valid only with PREADY=1.

## Operation
- Index: LSB = log2(DATA_WIDTH/8); idx = PADDR[ADDR_WIDTH-1:LSB].
- Error (err) if PADDR[LSB-1:0] ≠ 0 (misaligned) or idx ≥ DEPTH.
- States: INIT, IDLE, ACCESS.
- INIT (only if CLEAR_ON_RESET=1): clear counter 0→DEPTH-1, one word zeroed per cycle; bus ignored, PREADY=0; after word DEPTH-1 → IDLE. With CLEAR_ON_RESET=0 reset goes straight to IDLE.
- IDLE: if PSEL=1 (PENABLE either value, so transfers stalled by INIT are picked up) → capture err, idx; load wait counter with WAIT_STATES; load PRDATA with mem[idx] for a valid read, 0 for an erroneous read, unchanged for a write; → ACCESS.
- ACCESS: PREADY = (wait counter == 0); counter decrements each cycle while ≠ 0. PSLVERR = PREADY & err.
- Completion edge (PSEL & PENABLE & PREADY): valid write updates mem[idx] bytes where PSTRB=1; erroneous write changes nothing; → IDLE.
- PSEL low in ACCESS (protocol abort): no write, → IDLE, PRDATA unchanged.
- Read after write to the same word in the next transfer returns the new data.
- PSTRB=0 on a valid write: OKAY response, memory unchanged.

## Timing
- Reset (asynchronous, immediate): PRDATA=0, PREADY=0, PSLVERR=0, wait counter=0, state=INIT or IDLE per CLEAR_ON_RESET. Reset mid-transfer aborts it; no partial write.
- INIT lasts exactly DEPTH cycles after PRESETn rises.
- PREADY, PSLVERR combinational from state/counter/err flop; no combinational path from bus inputs.
- Transfer length: SETUP 1 cycle + ACCESS WAIT_STATES+1 cycles; back-to-back transfers with no idle cycle between (next SETUP seen in IDLE on the cycle after completion).
- PRDATA stable from first ACCESS cycle until next read capture.

## Structure
- Package apb4_ram_pkg: state enum (INIT, IDLE, ACCESS), response constants RESP_OKAY/RESP_ERR, function computing LSB from DATA_WIDTH.
- Sub-module apb4_ram_array: DEPTH×DATA_WIDTH storage, one read port, one byte-enable write port, plus clear port used by INIT.

## Test plan
- Reset, CLEAR_ON_RESET=1, DEPTH=32: PREADY=0 for 32 cycles; then read idx 5 → PRDATA=0, PSLVERR=0.
- WAIT_STATES=0: write 0xDEADBEEF to 0x10, read 0x10 back-to-back → 2-cycle transfers, PRDATA=0xDEADBEEF.
- WAIT_STATES=3: write then read 0x04 → PREADY low 3 ACCESS cycles, high on 4th; data 0x12345678 returned.
- Byte strobes: write 0xFFFFFFFF, then 0x00000000 with PSTRB=0101 → read 0xFF00FF00.
- Errors: read 0x80 (idx 32 ≥ DEPTH) → PSLVERR=1, PRDATA=0; write 0x02 (misaligned) → PSLVERR=1, mem[0] unchanged.
- PRESETn pulsed low mid-ACCESS of a write with WAIT_STATES=2 → outputs 0 immediately, target word reads 0 after INIT.
